leaf_fifo_stage: RTL
====================

LEAF_FIFO_STAGE -- requirements
Module: leaf_fifo_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (legal 1..64).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (power of two, legal 2..64).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-006 SHALL have port in_ready  output  1  stage accepts a word this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port out_valid  output  1  out_data holds the oldest stored word.
REQ-009 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 SHALL have port out_data  output  DATA_W  oldest stored payload.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-012 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready, both sampled at the rising edge of clk.
REQ-013 SHALL drive in_ready = (count != DEPTH) combinationally from registered state, with no dependency on out_ready.
REQ-014 SHALL drive out_valid = (count != 0) and out_data = storage[rd_ptr], both registered-state-derived with no combinational path from in_*.
REQ-015 SHALL have a latency of exactly one cycle: a word pushed at edge N is visible on out_data/out_valid after edge N and is poppable at edge N+1.
REQ-016 SHALL deliver words in strict FIFO order, with no loss or duplication.
REQ-017 SHALL update count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-018 SHALL, when full, hold in_ready=0 and ignore in_valid; a pop in the same cycle does not enable a push until the next cycle.
REQ-019 SHALL, when empty, hold out_valid=0 and ignore out_ready; out_data is don't-care while empty.
REQ-020 SHALL keep read and write pointers $clog2(DEPTH) bits wide, each incrementing modulo DEPTH and wrapping from DEPTH-1 to 0 without a gap.
REQ-021 SHALL leave stored entries unmodified when in_valid=1 while in_ready=0.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, clear rd_ptr, wr_ptr and count to 0, giving out_valid=0, in_ready=1 and count=0 after that edge.
REQ-023 SHALL discard all stored words when rst is asserted mid-operation; push and pop in that cycle are ignored.
REQ-024 SHALL NOT reset the storage array contents.

Configuration
REQ-025 SHALL honour macro LEAF_FIFO_PARITY_EN: when defined, each entry stores an extra bit equal to the XOR of in_data at push time, and an output port out_parity (1 bit) presents that bit for the oldest entry; out_parity is 0 while empty.
REQ-026 SHALL, when LEAF_FIFO_PARITY_EN is undefined, have no out_parity port and no parity storage; all other behaviour is identical.

Structure
REQ-027 SHALL take DEFAULT_DATA_W, DEFAULT_DEPTH and the ptr_t/cnt_t width helper functions from shared package leaf_pkg.
REQ-028 SHALL place storage in one sub-module, leaf_fifo_mem (one write port, one asynchronous read port, no reset); pointer and count control stays in leaf_fifo_stage.

Verification
REQ-029 SHALL cover: reset, then 0xA5 pushed at cycle 1 -> out_valid=1, out_data=0xA5, count=1 after edge 1.
REQ-030 SHALL cover: out_ready=0, 5 pushes of 0x01..0x05 at DEPTH=4 -> in_ready=0 after the 4th, count=4, 0x05 not stored; draining yields 0x01..0x04.
REQ-031 SHALL cover: count=2, simultaneous push of 0x33 and pop -> count stays 2, and the popped word is the oldest.
REQ-032 SHALL cover: 10 words 0x10..0x19 streamed with out_ready=1 -> pointers wrap twice and output order is 0x10..0x19 with no gaps.
REQ-033 SHALL cover: rst asserted with count=3 -> count=0, out_valid=0, in_ready=1 after that edge; the next push of 0x77 appears as the first output.
REQ-034 SHALL cover, with LEAF_FIFO_PARITY_EN: pushes of 0x07 then 0x03 -> out_parity=1, then 0 after the pop.

Source files
------------

// File: rtl/leaf_pkg.sv
// Shared defaults and width helpers for the leaf FIFO stage and its storage.
package leaf_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 4;

    // Width of a read/write pointer (ptr_t) for a given entry count.
    function automatic int ptr_t_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of the occupancy counter (cnt_t); one extra bit so that
    // "full" (count == depth) is representable.
    function automatic int cnt_t_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/leaf_fifo_mem.sv
// Storage array for the leaf FIFO stage: one synchronous write port and one
// asynchronous read port. Contents carry no reset.
module leaf_fifo_mem
    import leaf_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = ptr_t_width(DEFAULT_DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the addressed entry on an accepted push.
    // NOTE: storage is deliberately left out of reset; the pointers alone
    // define which entries are valid, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/leaf_fifo_stage.sv
// Single-clock valid/ready FIFO stage with one cycle of latency.
// Optional feature: define LEAF_FIFO_PARITY_EN to store an XOR parity bit
// with each word and present it for the oldest entry on out_parity.
module leaf_fifo_stage
    import leaf_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic [cnt_t_width(DEPTH)-1:0]   count
`ifdef LEAF_FIFO_PARITY_EN
    ,
    output logic                            out_parity
`endif
);

    localparam int PTR_W = ptr_t_width(DEPTH);
    localparam int CNT_W = cnt_t_width(DEPTH);
`ifdef LEAF_FIFO_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);

    ptr_t             r_rd_ptr;
    ptr_t             r_wr_ptr;
    cnt_t             r_count;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_mem_we;
    logic [MEM_W-1:0] w_wr_word;
    logic [MEM_W-1:0] w_rd_word;

    // Handshake flags come only from registered occupancy, so neither ready
    // nor valid depends combinationally on the opposite side.
    assign w_in_ready  = (r_count != FULL_COUNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid  & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    // A push coinciding with reset is discarded, so the array is not written.
    assign w_mem_we    = w_push & ~rst;

`ifdef LEAF_FIFO_PARITY_EN
    assign w_wr_word   = {^in_data, in_data};
`else
    assign w_wr_word   = in_data;
`endif

    leaf_fifo_mem #(
        .WIDTH  (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_word),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_word)
    );

    // Advance pointers and occupancy on accepted push/pop; DEPTH is a power
    // of two, so natural pointer overflow gives the modulo-DEPTH wrap.
    // NOTE: state registers use non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_data   = w_rd_word[DATA_W-1:0];
    assign count      = r_count;
`ifdef LEAF_FIFO_PARITY_EN
    assign out_parity = w_out_valid & w_rd_word[DATA_W];
`endif

endmodule
